// File: rtl/seq_ctrl_ws_pkg.sv
// Shared phase/opcode types and helpers for the VeriRisc sequence controller.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    // Opcodes wider than this carry reserved encodings that run as NOP.
    localparam int unsigned STD_OPC_W  = 3;
    localparam int unsigned WAIT_CNT_W = 8;

    function automatic logic is_aluop(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/seq_ctrl_ws_if.sv
// Controller <-> datapath bundle: IR/flag/memory inputs and the control strobes.
interface seq_ctrl_ws_if #(
    parameter int unsigned OPC_W = 3
);
    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             mem_rdy;
    logic             resume;

    logic             rd;
    logic             wr;
    logic             ld_ir;
    logic             ld_acc;
    logic             ld_pc;
    logic             inc_pc;
    logic             halt;
    logic             data_e;
    logic             sel;
    logic [2:0]       phase;
    logic             timeout;

    modport master (
        input  opcode, zero, mem_rdy, resume,
        output rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel, phase, timeout
    );

    modport slave (
        output opcode, zero, mem_rdy, resume,
        input  rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel, phase, timeout
    );
endinterface

// File: rtl/seq_ctrl_ws_decode.sv
// Combinational strobe decode from phase, opcode, zero flag and first-cycle flag.
module seq_ctrl_decode
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 3
) (
    input  phase_e           phase_i,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             zero_i,
    input  logic             first_i,
    output logic             rd_o,
    output logic             wr_o,
    output logic             ld_ir_o,
    output logic             ld_acc_o,
    output logic             ld_pc_o,
    output logic             inc_pc_o,
    output logic             halt_o,
    output logic             data_e_o,
    output logic             sel_o
);

    logic    std_op;
    opcode_e op;
    logic    alu_op;
    logic    hlt_op;
    logic    skz_op;
    logic    sto_op;
    logic    jmp_op;

    always_comb begin
        std_op = ((opcode_i >> STD_OPC_W) == '0);
        op     = opcode_e'(opcode_i[STD_OPC_W-1:0]);
        alu_op = std_op && is_aluop(op);
        hlt_op = std_op && (op == OP_HLT);
        skz_op = std_op && (op == OP_SKZ);
        sto_op = std_op && (op == OP_STO);
        jmp_op = std_op && (op == OP_JMP);
    end

    always_comb begin
        rd_o     = 1'b0;
        wr_o     = 1'b0;
        ld_ir_o  = 1'b0;
        ld_acc_o = 1'b0;
        ld_pc_o  = 1'b0;
        inc_pc_o = 1'b0;
        halt_o   = 1'b0;
        data_e_o = 1'b0;
        sel_o    = 1'b0;
        case (phase_i)
            INST_ADDR: begin
                sel_o = 1'b1;
            end
            INST_FETCH: begin
                sel_o = 1'b1;
                rd_o  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel_o   = 1'b1;
                rd_o    = 1'b1;
                ld_ir_o = 1'b1;
            end
            // Reserved opcodes still step the PC past themselves here.
            OP_ADDR: begin
                inc_pc_o = first_i;
                halt_o   = hlt_op;
            end
            OP_FETCH: begin
                rd_o = alu_op;
            end
            ALU_OP: begin
                rd_o     = alu_op;
                inc_pc_o = skz_op && zero_i;
                ld_pc_o  = jmp_op;
                data_e_o = sto_op;
            end
            STORE: begin
                rd_o     = alu_op;
                ld_acc_o = alu_op;
                ld_pc_o  = jmp_op;
                wr_o     = sto_op;
                data_e_o = sto_op;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_ctrl_ws.sv
// VeriRisc sequence controller with memory wait states, resumable halt and stall watchdog.
// Build macro SEQ_CTRL_WAIT_EN enables mem_rdy stalls and the watchdog.
//
// state      | meaning
// INST_ADDR  | drive PC onto address bus
// INST_FETCH | read instruction (memory phase)
// INST_LOAD  | load IR
// IDLE       | IR settle
// OP_ADDR    | step PC (first cycle); park here on HLT until resume
// OP_FETCH   | read operand (memory phase for ALU ops)
// ALU_OP     | execute / skip / jump
// STORE      | write back (memory phase for STO)
module seq_ctrl_ws
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W    = 3,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_ctrl_ws_if.master bus
);

    phase_e phase_q, phase_d;
    logic   hold_q, hold_d;
    logic   advance;
    logic   wd_fire;

    logic   rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel;

`ifdef SEQ_CTRL_WAIT_EN
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                  mem_phase;
`else
    logic unused_wait;
    assign unused_wait = bus.mem_rdy ^ (MAX_WAIT == 0);
`endif

    seq_ctrl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .phase_i  (phase_q),
        .opcode_i (bus.opcode),
        .zero_i   (bus.zero),
        .first_i  (!hold_q),
        .rd_o     (rd),
        .wr_o     (wr),
        .ld_ir_o  (ld_ir),
        .ld_acc_o (ld_acc),
        .ld_pc_o  (ld_pc),
        .inc_pc_o (inc_pc),
        .halt_o   (halt),
        .data_e_o (data_e),
        .sel_o    (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= INST_ADDR;
            hold_q      <= 1'b0;
`ifdef SEQ_CTRL_WAIT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            phase_q     <= phase_d;
            hold_q      <= hold_d;
`ifdef SEQ_CTRL_WAIT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    always_comb begin
        advance = 1'b1;
        wd_fire = 1'b0;
`ifdef SEQ_CTRL_WAIT_EN
        mem_phase   = (phase_q == INST_FETCH) ||
                      ((phase_q == OP_FETCH) && rd) ||
                      ((phase_q == STORE) && wr);
        stall_cnt_d = stall_cnt_q;
        if ((phase_q == OP_ADDR) && halt) begin
            advance = bus.resume;
        end else if (mem_phase && !bus.mem_rdy) begin
            // Watchdog takes over the advance once the stall budget is spent.
            if (stall_cnt_q == WAIT_LIMIT) begin
                wd_fire = 1'b1;
            end else begin
                advance     = 1'b0;
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
        if (advance) begin
            stall_cnt_d = '0;
        end
`else
        if ((phase_q == OP_ADDR) && halt) begin
            advance = bus.resume;
        end
`endif
        phase_d = advance ? phase_e'(phase_q + 3'd1) : phase_q;
        hold_d  = !advance;
    end

    always_comb begin
        bus.rd      = rd;
        bus.wr      = wr;
        bus.ld_ir   = ld_ir;
        bus.ld_acc  = ld_acc;
        bus.ld_pc   = ld_pc;
        bus.inc_pc  = inc_pc;
        bus.halt    = halt;
        bus.data_e  = data_e;
        bus.sel     = sel;
        bus.phase   = phase_q;
        bus.timeout = wd_fire;
    end

endmodule

// File: tb/tb_seq_ctrl_ws.sv
// Instruction-level bench for seq_ctrl_ws: plans each instruction's phase timeline and checks every cycle.
module tb_seq_ctrl_ws;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned MAX_WAIT = 4;
`ifdef SEQ_CTRL_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seq_ctrl_ws_if #(.OPC_W(OPC_W)) bus ();

    seq_ctrl_ws #(
        .OPC_W    (OPC_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Strobe vector order: {rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel}
    function automatic logic [8:0] exp_strb(input int p, input int op, input bit z, input bit first);
        bit std, alu, hlt, skz, sto, jmp;
        logic rd, wr, ldir, ldacc, ldpc, inc, hl, de, sel;
        std = (op < 8);
        alu = std && (op >= 2) && (op <= 5);
        hlt = std && (op == 0);
        skz = std && (op == 1);
        sto = std && (op == 6);
        jmp = std && (op == 7);
        {rd, wr, ldir, ldacc, ldpc, inc, hl, de, sel} = '0;
        case (p)
            0: sel = 1'b1;
            1: begin sel = 1'b1; rd = 1'b1; end
            2, 3: begin sel = 1'b1; rd = 1'b1; ldir = 1'b1; end
            4: begin inc = first; hl = hlt; end
            5: rd = alu;
            6: begin rd = alu; inc = skz && z; ldpc = jmp; de = sto; end
            7: begin rd = alu; ldacc = alu; ldpc = jmp; wr = sto; de = sto; end
            default: ;
        endcase
        return {rd, wr, ldir, ldacc, ldpc, inc, hl, de, sel};
    endfunction

    function automatic bit is_mem(input int p, input int op);
        bit std;
        std = (op < 8);
        return (p == 1) || ((p == 5) && std && (op >= 2) && (op <= 5)) || ((p == 7) && std && (op == 6));
    endfunction

    function automatic logic [8:0] obs_strb();
        return {bus.rd, bus.wr, bus.ld_ir, bus.ld_acc, bus.ld_pc,
                bus.inc_pc, bus.halt, bus.data_e, bus.sel};
    endfunction

    // Runs phases 0..last_p of one instruction; caller must be positioned just after a negedge.
    // s1/s5/s7: cycles mem_rdy is held low in that memory phase; dres: cycles before resume on HLT.
    task automatic run_phases(input int op, input bit z, input int s1, input int s5,
                              input int s7, input int dres, input int last_p);
        for (int p = 0; p <= last_p; p++) begin
            bit memp;
            bit to_last;
            int stall;
            int ncyc;
            memp    = WAIT_EN && is_mem(p, op);
            stall   = (p == 1) ? s1 : (p == 5) ? s5 : (p == 7) ? s7 : 0;
            to_last = 1'b0;
            if (memp) begin
                if (stall > int'(MAX_WAIT)) begin
                    ncyc    = MAX_WAIT + 1;
                    to_last = 1'b1;
                end else begin
                    ncyc = stall + 1;
                end
            end else if ((p == 4) && (op == 0)) begin
                ncyc = dres + 1;
            end else begin
                ncyc = 1;
            end
            for (int k = 0; k < ncyc; k++) begin
                bus.opcode  = OPC_W'(op);
                bus.zero    = z;
                bus.mem_rdy = memp ? (k >= stall) : 1'($urandom_range(0, 1));
                bus.resume  = ((p == 4) && (op == 0)) ? (k >= dres) : 1'($urandom_range(0, 1));
                #1;
                check("phase", 32'(bus.phase), 32'(p));
                check("strobes", 32'(obs_strb()), 32'(exp_strb(p, op, z, k == 0)));
                check("timeout", 32'(bus.timeout), 32'(memp && to_last && (k == ncyc - 1)));
                @(negedge clk);
            end
        end
    endtask

    task automatic run_instr(input int op, input bit z, input int s1, input int s5,
                             input int s7, input int dres);
        run_phases(op, z, s1, s5, s7, dres, 7);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.opcode  = OPC_W'(2);
        bus.zero    = 1'b0;
        bus.mem_rdy = 1'b0;
        bus.resume  = 1'b0;
        #22;
        check("reset_phase", 32'(bus.phase), 32'd0);
        check("reset_strobes", 32'(obs_strb()), 32'h001);
        check("reset_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(2, 1'b0, 0, 0, 0, 0);   // ADD, no stalls
        run_instr(6, 1'b0, 0, 0, 3, 0);   // STO, 3 stall cycles in STORE
        run_instr(5, 1'b1, 20, 0, 0, 0);  // LDA, INST_FETCH stuck -> watchdog
        run_instr(0, 1'b0, 0, 0, 0, 10);  // HLT, resume 10 cycles later
        run_instr(1, 1'b1, 0, 0, 0, 0);   // SKZ zero=1
        run_instr(7, 1'b0, 0, 0, 0, 0);   // JMP
        run_instr(1, 1'b0, 0, 0, 0, 0);   // SKZ zero=0
        run_instr(9, 1'b1, 2, 0, 0, 0);   // reserved
        run_instr(2, 1'b0, 1, 5, 2, 0);   // ADD, operand fetch times out
        run_instr(0, 1'b1, 0, 0, 0, 0);   // HLT resumed at once

        for (int i = 0; i < 80; i++) begin
            run_instr(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, MAX_WAIT + 2)), int'($urandom_range(0, MAX_WAIT + 2)),
                      int'($urandom_range(0, MAX_WAIT + 2)), int'($urandom_range(0, 5)));
        end

        // Abort mid-instruction while OP_FETCH is waiting on memory.
        run_phases(2, 1'b0, 0, 100, 0, 0, 4);
        bus.mem_rdy = 1'b0;
        bus.resume  = 1'b0;
        #1;
        check("abort_pre_phase", 32'(bus.phase), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_phase", 32'(bus.phase), 32'd0);
        check("abort_strobes", 32'(obs_strb()), 32'h001);
        check("abort_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(9, 1'b0, 0, 0, 0, 0);
        run_instr(6, 1'b0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
